// File: rtl/rr_demux_dispatch_1x4_pkg.sv
// rtl/rr_demux_dispatch_1x4_pkg.sv - shared lane types and skip-busy lane search for the dispatcher
package dispatch_pkg;

    localparam int NUM_LANES = 4;

    typedef logic [1:0] lane_idx_t;

    // First free lane scanning ptr, ptr+1, ... (mod 4); falls back to ptr when none is free.
    function automatic lane_idx_t next_free(lane_idx_t ptr, logic [NUM_LANES-1:0] free_mask);
        lane_idx_t res;
        lane_idx_t cand;
        res = ptr;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (free_mask[cand]) begin
                res = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_demux_dispatch_1x4_if.sv
// rtl/rr_demux_dispatch_1x4_if.sv - producer stream and four lane handshakes of the dispatcher
interface rr_demux_dispatch_1x4_if
    import dispatch_pkg::*;
#(
    parameter int WIDTH = 2
) ();

    logic [WIDTH-1:0]                  in_data;
    logic                              in_valid;
    logic                              in_ready;
    logic [NUM_LANES-1:0][WIDTH-1:0]   outp;
    logic [NUM_LANES-1:0]              out_valid;
    logic [NUM_LANES-1:0]              out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, outp, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, outp, out_valid
    );

endinterface

// File: rtl/rr_demux_dispatch_1x4_demux.sv
// rtl/rr_demux_dispatch_1x4_demux.sv - 1-to-4 demux, unselected outputs driven to zero
module demux_1x4
    import dispatch_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0]                 din,
    input  lane_idx_t                        sel,
    output logic [NUM_LANES-1:0][WIDTH-1:0]  dout
);

    always_comb begin
        dout      = '0;
        dout[sel] = din;
    end

endmodule

// File: rtl/rr_demux_dispatch_1x4.sv
// rtl/rr_demux_dispatch_1x4.sv - round-robin dispatcher feeding four 1-entry lane holding slots
module rr_demux_dispatch_1x4
    import dispatch_pkg::*;
#(
    parameter int WIDTH     = 2,
    parameter int SKIP_BUSY = 0,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    rr_demux_dispatch_1x4_if.slave bus,
    output lane_idx_t             sel,
    output logic [CNT_W-1:0]      dispatched_count
);

    lane_idx_t                        ptr;
    lane_idx_t                        tgt;
    logic [NUM_LANES-1:0]             lane_valid;
    logic [NUM_LANES-1:0][WIDTH-1:0]  lane_data;
    logic [NUM_LANES-1:0]             free;
    logic [NUM_LANES-1:0][0:0]        stb_raw;
    logic [NUM_LANES-1:0]             wr_stb;
    logic [NUM_LANES-1:0][WIDTH-1:0]  wr_data;
    logic                             accept;

    // A lane draining this cycle counts as free so it can be refilled without a bubble.
    assign free = ~lane_valid | bus.out_ready;

    always_comb begin
        tgt = ptr;
        if (SKIP_BUSY != 0) begin
            tgt = next_free(ptr, free);
        end
    end

    assign sel          = tgt;
    assign bus.in_ready = en & ~rst & free[tgt];
    assign accept       = bus.in_valid & bus.in_ready;

    demux_1x4 #(.WIDTH(1)) u_stb_demux (
        .din  (1'b1),
        .sel  (tgt),
        .dout (stb_raw)
    );

    demux_1x4 #(.WIDTH(WIDTH)) u_data_demux (
        .din  (bus.in_data),
        .sel  (tgt),
        .dout (wr_data)
    );

    assign wr_stb = stb_raw & {NUM_LANES{accept}};

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr              <= '0;
            dispatched_count <= '0;
            lane_valid       <= '0;
            lane_data        <= '0;
        end else begin
            if (accept) begin
                ptr              <= tgt + 2'd1;
                dispatched_count <= dispatched_count + CNT_W'(1);
            end
            for (int i = 0; i < NUM_LANES; i++) begin
                if (wr_stb[i]) begin
                    lane_valid[i] <= 1'b1;
                    lane_data[i]  <= wr_data[i];
                end else if (lane_valid[i] && bus.out_ready[i]) begin
                    lane_valid[i] <= 1'b0;
                    lane_data[i]  <= '0;
                end
            end
        end
    end

    assign bus.out_valid = lane_valid;
    assign bus.outp      = lane_data;

endmodule

// File: tb/tb_rr_demux_dispatch_1x4.sv
// tb/tb_rr_demux_dispatch_1x4.sv - scoreboard bench for strict (A) and skip-busy, 2-bit count (B) dispatchers
module tb_rr_demux_dispatch_1x4;
    import dispatch_pkg::*;

    localparam int W = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          en;
    logic [W-1:0]  din;
    logic          vin;
    logic [3:0]    ordy;

    rr_demux_dispatch_1x4_if #(.WIDTH(W)) ifa ();
    rr_demux_dispatch_1x4_if #(.WIDTH(W)) ifb ();

    assign ifa.in_data   = din;
    assign ifa.in_valid  = vin;
    assign ifa.out_ready = ordy;
    assign ifb.in_data   = din;
    assign ifb.in_valid  = vin;
    assign ifb.out_ready = ordy;

    lane_idx_t    sel_a, sel_b;
    logic [15:0]  cnt_a;
    logic [1:0]   cnt_b;

    rr_demux_dispatch_1x4 #(.WIDTH(W), .SKIP_BUSY(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .en(en), .bus(ifa), .sel(sel_a), .dispatched_count(cnt_a)
    );

    rr_demux_dispatch_1x4 #(.WIDTH(W), .SKIP_BUSY(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .bus(ifb), .sel(sel_b), .dispatched_count(cnt_b)
    );

    logic [3:0]         d_ov [2];
    logic [3:0][W-1:0]  d_op [2];
    logic               d_ir [2];
    int                 d_sel[2];
    int                 d_cnt[2];

    always_comb begin
        d_ov[0]  = ifa.out_valid;  d_ov[1]  = ifb.out_valid;
        d_op[0]  = ifa.outp;       d_op[1]  = ifb.outp;
        d_ir[0]  = ifa.in_ready;   d_ir[1]  = ifb.in_ready;
        d_sel[0] = int'(sel_a);    d_sel[1] = int'(sel_b);
        d_cnt[0] = int'(cnt_a);    d_cnt[1] = int'(cnt_b);
    end

    // Reference: lanes as plain arrays, pointer/count as integers.
    int mv   [2][4];
    int md   [2][4];
    int mptr [2];
    int mcnt [2];
    int cmod [2] = '{65536, 4};
    int sbq  [8][$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int d, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut=%0d t=%0t got=%0d expected=%0d", name, d, $time, act, exp);
        end
    endtask

    function automatic int lane_free(int d, int j);
        return (mv[d][j] == 0 || ordy[j] == 1'b1) ? 1 : 0;
    endfunction

    function automatic int target(int d);
        if (d == 0) return mptr[d];
        for (int k = 0; k < 4; k++) begin
            if (lane_free(d, (mptr[d] + k) % 4) != 0) return (mptr[d] + k) % 4;
        end
        return mptr[d];
    endfunction

    task automatic step(input bit r, input bit e, input bit v, input int data, input logic [3:0] rdy);
        int tg[2];
        int ac[2];
        @(negedge clk);
        rst = r; en = e; vin = v; din = data[W-1:0]; ordy = rdy;
        #2;
        for (int d = 0; d < 2; d++) begin
            tg[d] = target(d);
            ac[d] = 0;
            chk("in_ready", d, int'(d_ir[d]), (e && !r && lane_free(d, tg[d]) != 0) ? 1 : 0);
            chk("sel", d, d_sel[d], tg[d]);
            chk("count", d, d_cnt[d], mcnt[d]);
            for (int i = 0; i < 4; i++) begin
                chk("out_valid", d, int'(d_ov[d][i]), mv[d][i]);
                chk("outp", d, int'(d_op[d][i]), mv[d][i] != 0 ? md[d][i] : 0);
            end
            if (v && e && !r && lane_free(d, tg[d]) != 0) begin
                ac[d] = 1;
                sbq[d*4 + tg[d]].push_back(data % 4);
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                mptr[d] = 0;
                mcnt[d] = 0;
                for (int i = 0; i < 4; i++) begin
                    mv[d][i] = 0;
                    md[d][i] = 0;
                    sbq[d*4 + i].delete();
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (ac[d] != 0 && tg[d] == i) begin
                        mv[d][i] = 1;
                        md[d][i] = data % 4;
                    end else if (mv[d][i] != 0 && rdy[i]) begin
                        mv[d][i] = 0;
                        md[d][i] = 0;
                    end
                end
                if (ac[d] != 0) begin
                    mptr[d] = (tg[d] + 1) % 4;
                    mcnt[d] = (mcnt[d] + 1) % cmod[d];
                end
            end
        end
    endtask

    // Monitor: every lane handshake must deliver the oldest beat queued for that lane.
    always @(negedge clk) begin
        #3;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                if (d_ov[d][i] === 1'b1 && ordy[i] === 1'b1) begin
                    if (sbq[d*4 + i].size() == 0) begin
                        chk("unexpected_beat", d, 1, 0);
                    end else begin
                        chk("lane_data", d, int'(d_op[d][i]), sbq[d*4 + i].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; vin = 1'b0; din = '0; ordy = '0;
        for (int d = 0; d < 2; d++) begin
            mptr[d] = 0;
            mcnt[d] = 0;
            for (int i = 0; i < 4; i++) begin
                mv[d][i] = 0;
                md[d][i] = 0;
            end
        end
        step(1, 0, 0, 0, 4'h0);
        step(1, 1, 1, 1, 4'hF);

        // Full-rate stream 0..4 across all lanes, wrapping the pointer.
        for (int i = 0; i < 5; i++) step(0, 1, 1, i, 4'hF);
        step(0, 1, 0, 0, 4'hF);

        // Enable low mid-stream.
        step(0, 0, 1, 2, 4'hF);
        step(0, 0, 1, 3, 4'hF);
        step(0, 1, 1, 1, 4'hF);

        // Fill every lane, then hold lane 1 busy while others are ready.
        for (int i = 0; i < 4; i++) step(0, 1, 1, i, 4'h0);
        step(0, 1, 1, 2, 4'b0001);
        step(0, 1, 1, 3, 4'b1101);
        step(0, 1, 1, 0, 4'b1101);
        step(0, 1, 1, 1, 4'hF);

        // Reset with lanes full and a beat offered.
        for (int i = 0; i < 3; i++) step(0, 1, 1, i, 4'h0);
        step(1, 1, 1, 3, 4'h0);
        step(0, 1, 1, 2, 4'h0);
        step(0, 1, 0, 0, 4'hF);

        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 150) == 0, ($urandom % 8) != 0, ($urandom % 4) != 0,
                 int'($urandom % 4), 4'($urandom));
        end

        for (int n = 0; n < 3; n++) step(0, 1, 0, 0, 4'hF);
        for (int q = 0; q < 8; q++) chk("leftover", q / 4, sbq[q].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
